// File: rtl/ysyx_24080014_axil_sram.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080014_axil_sram
// Brief    : AXI4-Lite word-array responder with independent read/write FSMs
//            and programmable response latency.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24080014_axil_sram #(
  parameter int                 ADDR_W     = 32,
  parameter int                 DEPTH_LOG2 = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h8000_0000,
  parameter int                 RD_LAT     = 1,
  parameter int                 WR_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int         c_DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  logic [31:0] r_mem [c_DEPTH];

  rstate_t             r_rstate;
  logic [ADDR_W-1:0]   r_araddr;
  logic [3:0]          r_rcnt;
  logic [ADDR_W-1:0]   w_roff;
  logic                w_rin;
  logic [DEPTH_LOG2-1:0] w_ridx;

  wstate_t             r_wstate;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [3:0]          r_wcnt;
  logic [ADDR_W-1:0]   w_woff;
  logic                w_win;
  logic [DEPTH_LOG2-1:0] w_widx;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_commit;

  // Offset wraps for addresses below the base, so one upper-bit test covers both bounds.
  assign w_roff = r_araddr - BASE_ADDR;
  assign w_rin  = (w_roff >> (DEPTH_LOG2 + 2)) == '0;
  assign w_ridx = w_roff[DEPTH_LOG2+1:2];

  assign w_woff = r_awaddr - BASE_ADDR;
  assign w_win  = (w_woff >> (DEPTH_LOG2 + 2)) == '0;
  assign w_widx = w_woff[DEPTH_LOG2+1:2];

  assign w_aw_hs  = awvalid && awready;
  assign w_w_hs   = wvalid && wready;
  assign w_commit = (r_wstate == W_WAIT) && (r_rcnt_zero_w()) && w_win && !rst;

  function automatic logic r_rcnt_zero_w();
    return r_wcnt == 4'd0;
  endfunction

  // The wait state always runs one extra tick with the counter at zero, which
  // places the response exactly LAT+1 cycles after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= c_OKAY;
      r_araddr <= '0;
      r_rcnt   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (arvalid) begin
          r_araddr <= araddr;
          r_rcnt   <= 4'(RD_LAT);
          arready  <= 1'b0;
          r_rstate <= R_WAIT;
        end
        R_WAIT: if (r_rcnt == 4'd0) begin
          rdata    <= w_rin ? r_mem[w_ridx] : '0;
          rresp    <= w_rin ? c_OKAY : c_SLVERR;
          rvalid   <= 1'b1;
          r_rstate <= R_RESP;
        end else begin
          r_rcnt <= r_rcnt - 4'd1;
        end
        R_RESP: if (rready) begin
          rvalid   <= 1'b0;
          arready  <= 1'b1;
          r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      awready  <= 1'b1;
      wready   <= 1'b1;
      bvalid   <= 1'b0;
      bresp    <= c_OKAY;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_wcnt   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr <= awaddr;
            awready  <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            wready  <= 1'b0;
          end
          // A dropped ready means that channel was already captured.
          if ((w_aw_hs || !awready) && (w_w_hs || !wready)) begin
            r_wcnt   <= 4'(WR_LAT);
            r_wstate <= W_WAIT;
          end
        end
        W_WAIT: if (r_wcnt == 4'd0) begin
          bresp    <= w_win ? c_OKAY : c_SLVERR;
          bvalid   <= 1'b1;
          r_wstate <= W_RESP;
        end else begin
          r_wcnt <= r_wcnt - 4'd1;
        end
        W_RESP: if (bready) begin
          bvalid   <= 1'b0;
          awready  <= 1'b1;
          wready   <= 1'b1;
          r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_mem[w_widx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080014_axil_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24080014_axil_sram
// Brief    : Randomized bench for the AXI4-Lite SRAM responder against a
//            word-map reference model; two instances cover two latency setups.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24080014_axil_sram;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;

  logic        a_arvalid, a_rready, a_awvalid, a_wvalid, a_bready;
  logic        b_arvalid, b_rready, b_awvalid, b_wvalid, b_bready;
  logic        a_arready, a_rvalid, a_awready, a_wready, a_bvalid;
  logic        b_arready, b_rvalid, b_awready, b_wready, b_bvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [1:0]  a_rresp, b_rresp, a_bresp, b_bresp;

  logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;

  assign a_arvalid = arvalid & ~sel;  assign b_arvalid = arvalid & sel;
  assign a_rready  = rready  & ~sel;  assign b_rready  = rready  & sel;
  assign a_awvalid = awvalid & ~sel;  assign b_awvalid = awvalid & sel;
  assign a_wvalid  = wvalid  & ~sel;  assign b_wvalid  = wvalid  & sel;
  assign a_bready  = bready  & ~sel;  assign b_bready  = bready  & sel;

  assign m_arready = sel ? b_arready : a_arready;
  assign m_rvalid  = sel ? b_rvalid  : a_rvalid;
  assign m_awready = sel ? b_awready : a_awready;
  assign m_wready  = sel ? b_wready  : a_wready;
  assign m_bvalid  = sel ? b_bvalid  : a_bvalid;
  assign m_rdata   = sel ? b_rdata   : a_rdata;
  assign m_rresp   = sel ? b_rresp   : a_rresp;
  assign m_bresp   = sel ? b_bresp   : a_bresp;

  ysyx_24080014_axil_sram #(.DEPTH_LOG2(8), .RD_LAT(2), .WR_LAT(3)) dut_a (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(a_arvalid), .arready(a_arready),
    .rdata(a_rdata), .rresp(a_rresp), .rvalid(a_rvalid), .rready(a_rready),
    .awaddr(awaddr), .awvalid(a_awvalid), .awready(a_awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(a_wvalid), .wready(a_wready),
    .bresp(a_bresp), .bvalid(a_bvalid), .bready(a_bready)
  );

  ysyx_24080014_axil_sram #(.RD_LAT(0), .WR_LAT(0)) dut_b (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(b_arvalid), .arready(b_arready),
    .rdata(b_rdata), .rresp(b_rresp), .rvalid(b_rvalid), .rready(b_rready),
    .awaddr(awaddr), .awvalid(b_awvalid), .awready(b_awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(b_wvalid), .wready(b_wready),
    .bresp(b_bresp), .bvalid(b_bvalid), .bready(b_bready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mdl_a [int unsigned];
  logic [31:0] mdl_b [int unsigned];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rd_lat();
    return sel ? 0 : 2;
  endfunction

  function automatic int wr_lat();
    return sel ? 0 : 3;
  endfunction

  function automatic bit in_range(input logic [31:0] addr);
    longint unsigned lo, hi;
    lo = 64'h8000_0000;
    hi = lo + (64'd4 << (sel ? 16 : 8));
    return (64'(addr) >= lo) && (64'(addr) < hi);
  endfunction

  function automatic int unsigned widx(input logic [31:0] addr);
    return (addr - 32'h8000_0000) >> 2;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] addr);
    int unsigned k;
    k = widx(addr);
    if (!in_range(addr)) return 32'h0;
    if (sel) return mdl_b.exists(k) ? mdl_b[k] : 32'h0;
    return mdl_a.exists(k) ? mdl_a[k] : 32'h0;
  endfunction

  task automatic mdl_wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    if (!in_range(addr)) return;
    cur = mdl_rd(addr);
    for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
    if (sel) mdl_b[widx(addr)] = cur;
    else     mdl_a[widx(addr)] = cur;
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    bit hs;
    int n;
    exp_d = mdl_rd(addr);
    exp_r = in_range(addr) ? 2'b00 : 2'b10;
    araddr = addr; arvalid = 1'b1; rready = (stall == 0);
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin hs = m_arready; tick(); n++; end
    arvalid = 1'b0;
    if (!hs) check("ar_timeout", 32'd0, 32'd1);
    n = 0;
    while (!m_rvalid && n < 50) begin tick(); n++; end
    check("rd_latency", n, rd_lat() + 1);
    check("rdata", m_rdata, exp_d);
    check("rresp", {30'd0, m_rresp}, {30'd0, exp_r});
    for (int i = 0; i < stall; i++) begin
      tick();
      check("r_hold_valid", {31'd0, m_rvalid}, 32'd1);
      check("r_hold_data", m_rdata, exp_d);
      check("ar_low_in_resp", {31'd0, m_arready}, 32'd0);
    end
    rready = 1'b1; tick(); rready = 1'b0;
    check("r_done_valid", {31'd0, m_rvalid}, 32'd0);
    check("ar_ready_back", {31'd0, m_arready}, 32'd1);
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                          input int lead);
    int t_aw, t_w, n;
    bit aw_done, w_done, aw_hs, w_hs;
    t_aw = (lead > 0) ? lead : 0;
    t_w  = (lead < 0) ? -lead : 0;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    awaddr = addr; wdata = d; wstrb = s; bready = 1'b0;
    while (!(aw_done && w_done) && n < 50) begin
      awvalid = !aw_done && (n >= t_aw);
      wvalid  = !w_done && (n >= t_w);
      aw_hs = awvalid && m_awready;
      w_hs  = wvalid && m_wready;
      tick(); n++;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      if (w_done && !aw_done) check("wready_drop", {31'd0, m_wready}, 32'd0);
      if (aw_done && !w_done) check("awready_drop", {31'd0, m_awready}, 32'd0);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) check("w_timeout", 32'd0, 32'd1);
    n = 0;
    while (!m_bvalid && n < 50) begin tick(); n++; end
    check("wr_latency", n, wr_lat() + 1);
    check("bresp", {30'd0, m_bresp}, in_range(addr) ? 32'd0 : 32'd2);
    mdl_wr(addr, d, s);
    bready = 1'b1; tick(); bready = 1'b0;
    check("b_done_valid", {31'd0, m_bvalid}, 32'd0);
    check("aw_ready_back", {31'd0, m_awready}, 32'd1);
    check("w_ready_back", {31'd0, m_wready}, 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] old_d;
    sel = 1'b0; rst = 1'b1;
    araddr = 32'h8000_0000; arvalid = 1'b1; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) tick();
    check("rst_arready", {31'd0, m_arready}, 32'd1);
    check("rst_awready", {31'd0, m_awready}, 32'd1);
    check("rst_wready", {31'd0, m_wready}, 32'd1);
    check("rst_rvalid", {31'd0, m_rvalid}, 32'd0);
    check("rst_bvalid", {31'd0, m_bvalid}, 32'd0);
    check("rst_rdata", m_rdata, 32'd0);
    check("rst_rresp", {30'd0, m_rresp}, 32'd0);
    check("rst_bresp", {30'd0, m_bresp}, 32'd0);
    rst = 1'b0;
    tick();
    check("ar_first_cycle", {31'd0, m_arready}, 32'd0);
    arvalid = 1'b0;
    n = 0;
    while (!m_rvalid && n < 50) begin tick(); n++; end
    check("first_rd_latency", n, 32'd3);
    rready = 1'b1; tick(); rready = 1'b0;

    do_write(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 0);
    do_read(32'h8000_0000, 0);
    do_read(32'h8000_0000, 5);
    do_write(32'h8000_0004, 32'hAABB_CCDD, 4'hF, -1);
    do_write(32'h8000_0004, 32'h1122_3344, 4'b0101, 2);
    do_read(32'h8000_0004, 0);
    do_write(32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 0);
    do_read(32'h8000_0004, 1);
    do_read(32'h7FFF_FFFC, 0);
    do_write(32'h9000_0000, 32'h0BAD_0BAD, 4'hF, 0);
    do_write(32'h8000_0400, 32'h0BAD_0BAD, 4'hF, 1);
    do_write(32'h8000_03FC, 32'hCAFE_F00D, 4'hF, 0);
    do_read(32'h8000_03FC, 0);
    do_read(32'h8000_0400, 0);
    do_read(32'h8000_0000, 0);
    do_read(32'h8000_0004, 0);

    for (int i = 2; i < 16; i++) do_write(32'h8000_0000 + 32'(i * 4), $urandom, 4'hF, 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int unsigned w;
      w = $urandom_range(0, 16);
      a = (w == 16) ? 32'h8000_03FC : 32'h8000_0000 + 32'(w * 4);
      a[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       a = 32'h7FFF_FFFC;
          1:       a = 32'h8000_0400;
          default: a = 32'h9000_0000 + $urandom_range(0, 255);
        endcase
      end
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)) - 2);
      else
        do_read(a, int'($urandom_range(0, 2)));
    end

    // Zero-latency instance: simultaneous read and write of the same word.
    sel = 1'b1;
    do_write(32'h8000_0008, 32'h0, 4'hF, 0);
    old_d = mdl_rd(32'h8000_0008);
    araddr = 32'h8000_0008; awaddr = 32'h8000_0008; wdata = 32'h5A5A_5A5A; wstrb = 4'hF;
    check("cc_arready", {31'd0, m_arready}, 32'd1);
    check("cc_awready", {31'd0, m_awready}, 32'd1);
    check("cc_wready", {31'd0, m_wready}, 32'd1);
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("cc_rvalid", {31'd0, m_rvalid}, 32'd1);
    check("cc_bvalid", {31'd0, m_bvalid}, 32'd1);
    check("cc_rdata_old", m_rdata, old_d);
    check("cc_bresp", {30'd0, m_bresp}, 32'd0);
    mdl_wr(32'h8000_0008, 32'h5A5A_5A5A, 4'hF);
    tick();
    rready = 1'b0; bready = 1'b0;
    do_read(32'h8000_0008, 0);

    // Pending read response must not track a later write to its word.
    old_d = mdl_rd(32'h8000_0008);
    araddr = 32'h8000_0008; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    tick();
    check("hold_rvalid", {31'd0, m_rvalid}, 32'd1);
    do_write(32'h8000_0008, 32'h1234_5678, 4'hF, 0);
    check("hold_rdata", m_rdata, old_d);
    check("hold_rvalid2", {31'd0, m_rvalid}, 32'd1);
    rready = 1'b1; tick(); rready = 1'b0;
    do_read(32'h8000_0008, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
